// File: rtl/rv32_pkg.sv
// Shared types for the pito RV32 memory-side blocks: owner tags and arbiter FSM states.
package rv32_pkg;

  localparam int XPR_LEN = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  typedef enum logic {
    ARB_IDLE_ARB = 1'b0,
    ARB_LOCK     = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rv32_owner_fifo.sv
// One-bit in-order tag FIFO recording which port owns each outstanding memory transaction.
module rv32_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] slots_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push is accepted even when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = slots_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        slots_q[wr_ptr_q] <= din;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store, with data priority,
// a starvation guard for fetch, selection locking until accepted, and in-order response routing.
module rv32_mem_arbiter
  import rv32_pkg::*;
#(
  parameter int XLEN         = XPR_LEN,
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            rv32_clk,
  input  logic            rv32_rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e state_q, state_d;
  arb_owner_e lock_owner_q, lock_owner_d;
  arb_owner_e sel_owner;
  arb_owner_e head_owner;
  logic       sel_valid;
  logic [SW-1:0] starve_q, starve_d;
  logic       fifo_full, fifo_empty, fifo_head;
  logic       pop, blocked, xfer;
  logic       seen_push_q, proto_err_q;

  assign pop     = mem_rvalid && !fifo_empty;
  assign blocked = fifo_full && !pop;

  // While locked the other port is ignored; otherwise data wins unless fetch has waited too long.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OWN_D;
    if (state_q == ARB_LOCK) begin
      sel_valid = 1'b1;
      sel_owner = lock_owner_q;
    end else if (if_req && (starve_q == SW'(STARVE_LIMIT))) begin
      sel_valid = 1'b1;
      sel_owner = OWN_IF;
    end else if (d_req) begin
      sel_valid = 1'b1;
      sel_owner = OWN_D;
    end else if (if_req) begin
      sel_valid = 1'b1;
      sel_owner = OWN_IF;
    end
  end

  assign mem_req = rv32_rst_n && sel_valid && !blocked;
  assign xfer    = mem_req && mem_gnt;
  assign if_gnt  = xfer && (sel_owner == OWN_IF);
  assign d_gnt   = xfer && (sel_owner == OWN_D);

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (sel_owner == OWN_D) begin
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        mem_be   = 4'hF;
        mem_addr = if_addr;
      end
    end
  end

  // A blocked (full) cycle never reaches mem_req, so the FSM holds automatically.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    case (state_q)
      ARB_IDLE_ARB: begin
        if (mem_req && !mem_gnt) begin
          state_d      = ARB_LOCK;
          lock_owner_d = sel_owner;
        end
      end
      ARB_LOCK: begin
        if (xfer) state_d = ARB_IDLE_ARB;
      end
      default: state_d = ARB_IDLE_ARB;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (xfer && (sel_owner == OWN_D) && if_req) begin
      if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
    end else if ((xfer && (sel_owner == OWN_IF)) || !if_req) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge rv32_clk or negedge rv32_rst_n) begin
    if (!rv32_rst_n) begin
      state_q      <= ARB_IDLE_ARB;
      lock_owner_q <= OWN_IF;
      starve_q     <= '0;
      seen_push_q  <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      seen_push_q  <= seen_push_q | xfer;
      proto_err_q  <= proto_err_q | (mem_rvalid && fifo_empty && seen_push_q);
    end
  end

  rv32_owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk   (rv32_clk),
    .rst_n (rv32_rst_n),
    .push  (xfer),
    .pop   (pop),
    .din   (sel_owner == OWN_D),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_owner = fifo_head ? OWN_D : OWN_IF;
  assign if_rvalid  = pop && (head_owner == OWN_IF);
  assign d_rvalid   = pop && (head_owner == OWN_D);
  assign if_rdata   = if_rvalid ? mem_rdata : '0;
  assign d_rdata    = d_rvalid ? mem_rdata : '0;

  // Responses before any request since reset are stale leftovers and are dropped quietly.
  a_no_orphan_rvalid: assert property (@(posedge rv32_clk) disable iff (!rv32_rst_n) !proto_err_q);

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Randomized bench for rv32_mem_arbiter against a queue-based transaction model.
module tb_rv32_mem_arbiter;

  localparam int XLEN         = 32;
  localparam int MAX_OUTST    = 4;
  localparam int STARVE_LIMIT = 3;

  logic            clk;
  logic            rst_n;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;
  logic            d_req;
  logic            d_we;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  rv32_mem_arbiter #(
    .XLEN         (XLEN),
    .MAX_OUTST    (MAX_OUTST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .rv32_clk   (clk),
    .rv32_rst_n (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          is_store;
    logic [31:0] data;
  } txn_t;

  txn_t outst[$];
  bit   lock_valid;
  bit   lock_d;
  int   starve;
  int   errors = 0;
  int   checks = 0;

  int          p_if, p_d, p_gnt, p_rv;
  bit          stale_rv;
  bit          fix_d_addr;
  logic [31:0] fixed_d_addr;
  logic [31:0] pc;
  bit          exp_if_gnt, exp_d_gnt;
  bit          obs_mem_req, obs_if_rv, obs_d_rv, obs_any_gnt;
  logic [31:0] obs_mem_addr;
  int          gnt_log[$];
  int          rv_log[$];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int countOf(input int q[$], input int v);
    int n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    outst.delete();
    lock_valid = 0;
    lock_d     = 0;
    starve     = 0;
    exp_if_gnt = 0;
    exp_d_gnt  = 0;
  endtask

  // One clock cycle: drive requesters and memory, then compare against the model at negedge.
  task automatic applyStimulus();
    int          sel;
    bit          pop, blk, exp_req, exp_xfer;
    txn_t        head, t;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    @(posedge clk);
    #1;
    if (exp_if_gnt) begin
      if_req = 1'b0;
      pc     = pc + 32'd4;
    end
    if (exp_d_gnt) d_req = 1'b0;
    if (!if_req && int'($urandom_range(99)) < p_if) begin
      if_req  = 1'b1;
      if_addr = pc;
    end
    if (!d_req && int'($urandom_range(99)) < p_d) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_be    = d_we ? 4'($urandom_range(1, 15)) : 4'hF;
      d_addr  = fix_d_addr ? fixed_d_addr : {$urandom_range(32'h3FFF_FFFF), 2'b00};
      d_wdata = $urandom;
    end
    mem_gnt    = int'($urandom_range(99)) < p_gnt;
    mem_rvalid = stale_rv || (outst.size() > 0 && int'($urandom_range(99)) < p_rv);
    mem_rdata  = (outst.size() > 0) ? outst[0].data : $urandom;

    @(negedge clk);
    pop = mem_rvalid && (outst.size() > 0);
    if (pop) head = outst[0];
    blk = (outst.size() == MAX_OUTST) && !pop;
    if (lock_valid)                          sel = lock_d ? 2 : 1;
    else if (if_req && starve == STARVE_LIMIT) sel = 1;
    else if (d_req)                          sel = 2;
    else if (if_req)                         sel = 1;
    else                                     sel = 0;
    exp_req  = (sel != 0) && !blk;
    exp_xfer = exp_req && mem_gnt;
    e_addr   = (sel == 2) ? d_addr : if_addr;
    e_we     = (sel == 2) ? d_we : 1'b0;
    e_be     = (sel == 2) ? d_be : 4'hF;

    checkOutput("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      checkOutput("mem_addr", mem_addr, e_addr);
      checkOutput("mem_we", 32'(mem_we), 32'(e_we));
      checkOutput("mem_be", 32'(mem_be), 32'(e_be));
      if (sel == 2 && d_we) checkOutput("mem_wdata", mem_wdata, d_wdata);
    end
    exp_if_gnt = exp_xfer && (sel == 1);
    exp_d_gnt  = exp_xfer && (sel == 2);
    checkOutput("if_gnt", 32'(if_gnt), 32'(exp_if_gnt));
    checkOutput("d_gnt", 32'(d_gnt), 32'(exp_d_gnt));
    checkOutput("if_rvalid", 32'(if_rvalid), 32'(pop && !head.is_d));
    checkOutput("d_rvalid", 32'(d_rvalid), 32'(pop && head.is_d));
    if (pop && !head.is_store) begin
      if (head.is_d) checkOutput("d_rdata", d_rdata, head.data);
      else           checkOutput("if_rdata", if_rdata, head.data);
    end

    obs_mem_req  = mem_req;
    obs_mem_addr = mem_addr;
    obs_if_rv    = if_rvalid;
    obs_d_rv     = d_rvalid;
    obs_any_gnt  = if_gnt || d_gnt;
    if (if_gnt)    gnt_log.push_back(1);
    if (d_gnt)     gnt_log.push_back(2);
    if (if_rvalid) rv_log.push_back(1);
    if (d_rvalid)  rv_log.push_back(2);

    if (pop) void'(outst.pop_front());
    if (exp_xfer) begin
      t.is_d     = (sel == 2);
      t.is_store = (sel == 2) && d_we;
      t.data     = t.is_store ? $urandom : memData(e_addr);
      outst.push_back(t);
    end
    if (exp_req && !mem_gnt) begin
      lock_valid = 1;
      lock_d     = (sel == 2);
    end else if (exp_xfer) begin
      lock_valid = 0;
    end
    if (exp_xfer && sel == 2 && if_req) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
    else if ((exp_xfer && sel == 1) || !if_req) starve = 0;
  endtask

  task automatic drain();
    int i;
    p_if = 0; p_d = 0; p_gnt = 100; p_rv = 100;
    stale_rv = 0; fix_d_addr = 0;
    for (i = 0; i < 50 && (outst.size() > 0 || if_req || d_req); i++) applyStimulus();
    checkOutput("drain_done", 32'(outst.size() > 0 || if_req || d_req), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    p_if = 0; p_d = 0; p_gnt = 0; p_rv = 0; stale_rv = 0; fix_d_addr = 0; fixed_d_addr = '0;
    pc = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_gnts", 32'({if_gnt, d_gnt}), 32'd0);
    checkOutput("rst_rvalids", 32'({if_rvalid, d_rvalid}), 32'd0);
    rst_n = 1'b1;

    $display("[TB] fetch-only back-to-back");
    gnt_log.delete(); rv_log.delete();
    pc = 32'h0; p_if = 100; p_d = 0; p_gnt = 100; p_rv = 100;
    repeat (3) applyStimulus();
    checkOutput("t1_if_grants", 32'(countOf(gnt_log, 1)), 32'd3);
    drain();
    checkOutput("t1_if_resps", 32'(countOf(rv_log, 1)), 32'd3);
    checkOutput("t1_d_resps", 32'(countOf(rv_log, 2)), 32'd0);

    $display("[TB] simultaneous IF and D");
    gnt_log.delete(); rv_log.delete();
    fix_d_addr = 1; fixed_d_addr = 32'h100;
    p_if = 100; p_d = 100; p_gnt = 100; p_rv = 100;
    applyStimulus();
    p_if = 0; p_d = 0;
    applyStimulus();
    drain();
    checkOutput("t2_first_gnt", 32'(gnt_log.size() > 0 ? gnt_log[0] : 0), 32'd2);
    checkOutput("t2_second_gnt", 32'(gnt_log.size() > 1 ? gnt_log[1] : 0), 32'd1);
    checkOutput("t2_first_resp", 32'(rv_log.size() > 0 ? rv_log[0] : 0), 32'd2);
    checkOutput("t2_second_resp", 32'(rv_log.size() > 1 ? rv_log[1] : 0), 32'd1);

    $display("[TB] starvation guard");
    gnt_log.delete();
    p_if = 100; p_d = 100; p_gnt = 100; p_rv = 100;
    repeat (8) applyStimulus();
    pat = '0;
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) pat = {pat[6:0], gnt_log[i] == 2};
    checkOutput("t3_grant_count", 32'(gnt_log.size()), 32'd8);
    checkOutput("t3_pattern", 32'(pat), 32'h000000EE);
    drain();

    $display("[TB] lock while memory stalls");
    gnt_log.delete();
    fix_d_addr = 1; fixed_d_addr = 32'h200;
    p_if = 0; p_d = 100; p_gnt = 0; p_rv = 100;
    applyStimulus();
    p_d = 0; p_if = 100;
    repeat (2) begin
      applyStimulus();
      checkOutput("t4_lock_addr", obs_mem_addr, 32'h200);
    end
    p_if = 0; p_gnt = 100;
    repeat (2) applyStimulus();
    checkOutput("t4_first_gnt", 32'(gnt_log.size() > 0 ? gnt_log[0] : 0), 32'd2);
    checkOutput("t4_second_gnt", 32'(gnt_log.size() > 1 ? gnt_log[1] : 0), 32'd1);
    drain();

    $display("[TB] outstanding limit");
    gnt_log.delete();
    p_if = 100; p_d = 100; p_gnt = 100; p_rv = 0;
    repeat (6) applyStimulus();
    checkOutput("t5_grants_to_full", 32'(gnt_log.size()), 32'd4);
    checkOutput("t5_full_block", 32'(obs_mem_req), 32'd0);
    p_rv = 100;
    applyStimulus();
    checkOutput("t5_pop_grant", 32'(obs_any_gnt), 32'd1);
    drain();

    $display("[TB] reset with transactions outstanding");
    p_if = 0; p_d = 100; p_gnt = 100; p_rv = 0;
    repeat (2) applyStimulus();
    checkOutput("t6_outstanding", 32'(outst.size()), 32'd2);
    @(posedge clk);
    #1;
    if_req = 1; d_req = 1; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t6_rst_gnts", 32'({if_gnt, d_gnt}), 32'd0);
    checkOutput("t6_rst_rvalids", 32'({if_rvalid, d_rvalid}), 32'd0);
    checkOutput("t6_rst_rdata", if_rdata | d_rdata, 32'd0);
    if_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = 0;
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p_d = 0; stale_rv = 1;
    repeat (2) begin
      applyStimulus();
      checkOutput("t6_stale_if", 32'(obs_if_rv), 32'd0);
      checkOutput("t6_stale_d", 32'(obs_d_rv), 32'd0);
    end
    stale_rv = 0;

    $display("[TB] random traffic");
    for (int b = 0; b < 20; b++) begin
      p_if  = int'($urandom_range(100));
      p_d   = int'($urandom_range(100));
      p_gnt = int'($urandom_range(100, 20));
      p_rv  = int'($urandom_range(100, 10));
      repeat (100) applyStimulus();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
